manchester_frame_sequencer: RTL
===============================

MANCHESTER_FRAME_SEQUENCER -- requirements
Module: manchester_frame_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max idle clk cycles between decoded bits inside a frame (legal range 2..65535).
REQ-002 SHALL have parameter BROADCAST_ADDR, default 4'hF, meaning address accepted by every node.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse from Manchester decoder marking transmission begin.
REQ-006 SHALL have port bit_valid  input  1  one-cycle strobe; bit_data is valid this cycle.
REQ-007 SHALL have port bit_data  input  1  decoded Manchester data bit.
REQ-008 SHALL have port my_address  input  4  node address, quasi-static.
REQ-009 SHALL have port byte_out  output  8  last accepted payload byte, held until next acceptance.
REQ-010 SHALL have port byte_valid  output  1  one-cycle pulse when byte_out is updated.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse on parity, timeout or abort error.
REQ-013 SHALL have port frame_count  output  8  count of accepted frames, wraps 255->0.

Function
REQ-014 Frame format SHALL be 13 bits, MSB-first: 4 address bits, 8 payload bits, 1 parity bit; even parity over all 13 bits (XOR of all 13 == 0).
REQ-015 States SHALL be IDLE, ADDR, DATA, PARITY; 4-bit bit counter indexes bits within field.
REQ-016 IDLE: frame_start -> ADDR, bit counter 0, shift register cleared, timeout counter cleared; bit_valid ignored.
REQ-017 ADDR: each bit_valid shifts bit_data in; after 4th bit -> DATA, address_ok latched = (addr == my_address) or (addr == BROADCAST_ADDR), using my_address of that cycle.
REQ-018 DATA: each bit_valid shifts payload bit; after 8th bit -> PARITY.
REQ-019 PARITY: on bit_valid -> IDLE; parity good and address_ok: byte_out <= payload, byte_valid pulses next cycle, frame_count += 1 (mod 256).
REQ-020 Parity bad SHALL pulse frame_error next cycle regardless of address_ok; byte_out, frame_count unchanged.
REQ-021 Parity good, address mismatch SHALL produce no byte_valid, no frame_error, no count change.
REQ-022 Timeout: while busy, counter increments each cycle without bit_valid, clears on bit_valid; on reaching TIMEOUT_CYCLES -> IDLE and frame_error pulses that same cycle transition (visible next cycle).
REQ-023 frame_start while busy SHALL abort frame: frame_error pulses, restart in ADDR with counter 0, no byte_valid.
REQ-024 frame_start and bit_valid in same cycle SHALL take frame_start; that bit discarded.
REQ-025 byte_valid and frame_error SHALL never be high in same cycle.
REQ-026 Latency frame_start to busy high: 1 cycle; final parity bit strobe to byte_valid: 1 cycle.
REQ-027 Timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1); no wrap before timeout.

Reset
REQ-028 rst high at a rising edge SHALL force: state IDLE, byte_out 8'h00, byte_valid 0, busy 0, frame_error 0, frame_count 0, all internal counters 0.
REQ-029 rst mid-frame SHALL discard partial frame with no frame_error pulse; rst dominates frame_start and bit_valid in same cycle.

Verification
REQ-030 my_address=3; frame_start, bits 0011 10100101 0 -> byte_valid one cycle after parity strobe, byte_out=8'hA5, frame_count=1, no frame_error.
REQ-031 my_address=3; frame addr 5, payload 8'hA5, parity 0 -> no byte_valid, no frame_error, byte_out unchanged, busy low after 13th bit.
REQ-032 my_address=3; addr 4'hF, payload 8'h01, parity 1 -> byte_valid, byte_out=8'h01 (broadcast accepted).
REQ-033 my_address=3; addr 3, payload 8'hA5, parity 1 -> frame_error single pulse, byte_out and frame_count unchanged.
REQ-034 TIMEOUT_CYCLES=16; frame_start, 6 bits, then silence -> frame_error pulse 16 cycles after last bit strobe, busy low; second frame_start after 3 bits -> frame_error, busy stays high, following 13 good bits accepted.
REQ-035 256 accepted frames from reset -> frame_count returns to 0; rst asserted after 7 bits -> all outputs at reset values, no frame_error.

Source files
------------

// File: rtl/manchester_frame_sequencer.sv
// Assembles 13-bit Manchester frames (4b addr, 8b payload, even parity) into accepted payload bytes.
// Latency: frame_start to busy 1 cycle; parity bit strobe to byte_valid/frame_error 1 cycle.
// Backpressure: none; bit strobes are consumed as they arrive, idle gaps bounded by TIMEOUT_CYCLES.
module manchester_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [3:0]  BROADCAST_ADDR = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       bit_valid,
    input  logic       bit_data,
    input  logic [3:0] my_address,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       busy,
    output logic       frame_error,
    output logic [7:0] frame_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, PARITY} state_t;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_acc;
    logic          address_ok;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    addr_now;

    assign busy     = (state != IDLE);
    assign addr_now = {shift_reg[2:0], bit_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 8'h00;
            parity_acc  <= 1'b0;
            address_ok  <= 1'b0;
            tmo_cnt     <= '0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (frame_start) begin
                // A new start always wins; any frame in flight is abandoned as an error.
                if (state != IDLE)
                    frame_error <= 1'b1;
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                shift_reg  <= 8'h00;
                parity_acc <= 1'b0;
                address_ok <= 1'b0;
                tmo_cnt    <= '0;
            end else if (state != IDLE) begin
                if (bit_valid) begin
                    tmo_cnt <= '0;
                    case (state)
                        ADDR: begin
                            shift_reg  <= {shift_reg[6:0], bit_data};
                            parity_acc <= parity_acc ^ bit_data;
                            if (bit_cnt == 4'd3) begin
                                state      <= DATA;
                                bit_cnt    <= 4'd0;
                                address_ok <= (addr_now == my_address) ||
                                              (addr_now == BROADCAST_ADDR);
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        DATA: begin
                            shift_reg  <= {shift_reg[6:0], bit_data};
                            parity_acc <= parity_acc ^ bit_data;
                            if (bit_cnt == 4'd7) begin
                                state   <= PARITY;
                                bit_cnt <= 4'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        PARITY: begin
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                            if (parity_acc ^ bit_data) begin
                                frame_error <= 1'b1;
                            end else if (address_ok) begin
                                byte_out    <= shift_reg;
                                byte_valid  <= 1'b1;
                                frame_count <= frame_count + 8'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end else if (tmo_cnt == TMO_LAST) begin
                    // This idle cycle is the TIMEOUT_CYCLES-th since the last strobe.
                    state       <= IDLE;
                    bit_cnt     <= 4'd0;
                    tmo_cnt     <= '0;
                    frame_error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule
